// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops TX FIFO characters and shifts out start/data/parity/stop at 16x oversampling.
// Load costs one clk; tx is registered one clk behind the FSM; the FIFO is popped only when a frame slot opens.
module uart_tx_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_pop,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky,
    input  logic       bcb,
    output logic       tx,
    output logic       tsr_empty,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0] state_q, state_d;
    logic [4:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] wls_q, wls_d;
    logic       stb_q, stb_d;
    logic       pen_q, pen_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;

    logic [4:0] stop_last;
    logic [4:0] tick_last;
    logic       tick_done;
    logic [2:0] bit_last;
    logic       load;
    logic [7:0] data_masked;
    logic       par_calc;

    // 1.5 stop bits only exist for 5-bit words; otherwise stb selects 2.
    always_comb begin
        stop_last = 5'd15;
        if (stb_q) begin
            stop_last = (wls_q == 2'b00) ? 5'd23 : 5'd31;
        end
    end

    assign tick_last = (state_q == ST_STOP) ? stop_last : 5'd15;
    assign tick_done = baud_pulse && (tick_q == tick_last);
    assign bit_last  = 3'd4 + {1'b0, wls_q};

    // A slot opens in IDLE or on the final stop tick, giving back-to-back frames.
    assign load = rst && !fifo_empty &&
                  ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tick_done));
    assign fifo_pop = load;

    always_comb begin
        data_masked = fifo_dout;
        case (wls)
            2'b00:   data_masked = fifo_dout & 8'h1F;
            2'b01:   data_masked = fifo_dout & 8'h3F;
            2'b10:   data_masked = fifo_dout & 8'h7F;
            default: data_masked = fifo_dout;
        endcase
        if (sticky) begin
            par_calc = ~eps;
        end else if (eps) begin
            par_calc = ^data_masked;
        end else begin
            par_calc = ~^data_masked;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        wls_d   = wls_q;
        stb_d   = stb_q;
        pen_d   = pen_q;
        par_d   = par_q;

        if (state_q != ST_IDLE && baud_pulse) begin
            tick_d = tick_done ? 5'd0 : tick_q + 5'd1;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_START: begin
                if (tick_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == bit_last) begin
                        bit_d   = 3'd0;
                        state_d = pen_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick_done) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = 5'd0;
                bit_d   = 3'd0;
            end
        endcase

        // Line settings are captured only here, so mid-frame changes wait for the next character.
        if (load) begin
            state_d = ST_START;
            tick_d  = 5'd0;
            bit_d   = 3'd0;
            shift_d = fifo_dout;
            wls_d   = wls;
            stb_d   = stb;
            pen_d   = pen;
            par_d   = par_calc;
        end
    end

    always_comb begin
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
        if (bcb) begin
            tx_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tick_q  <= 5'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            wls_q   <= 2'b00;
            stb_q   <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wls_q   <= wls_d;
            stb_q   <= stb_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != ST_IDLE);
    assign tsr_empty = (state_q == ST_IDLE) && fifo_empty;

endmodule
